// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seg_scan multiplexed 7-segment driver.
package seg_pkg;

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] EN_OFF  = 8'hFF;

  // Active-low a..g patterns (a = bit 6), entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic logic [6:0] segLookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational hex nibble to active-low 7-segment pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = segLookup(nibble_i);

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 7-segment driver that displays a per-frame snapshot.
// Optional brightness control (bright port, 8-phase PWM per slot) with SEG_DIM_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 16384
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] num,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank,
`ifdef SEG_DIM_EN
  input  logic [2:0]          bright,
`endif
  output logic [6:0]          y,
  output logic                dp,
  output logic [DIGITS-1:0]   en,
  output logic                frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_ALL  = DIGITS'(EN_OFF);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snapNum_q, snapNum_d;
  logic [DIGITS-1:0]   snapDp_q, snapDp_d;
  logic [DIGITS-1:0]   snapBlank_q, snapBlank_d;
  logic [DIGITS-1:0]   selEn_q, selEn_d;
  logic [6:0]          y_q, y_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;
  logic                tick, frameTick;
  logic [3:0]          nibbleSel;
  logic [6:0]          segPat;
  logic                dpSel, blankSel;

  assign tick      = (cnt_q == CNT_MAX);
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign frameTick = tick && ((state_q == IDLE) || (idx_q == IDX_MAX));

  // The _d snapshot already holds the live inputs on the capture tick, so digit 0 sees them at once.
  assign snapNum_d   = frameTick ? num   : snapNum_q;
  assign snapDp_d    = frameTick ? dp_in : snapDp_q;
  assign snapBlank_d = frameTick ? blank : snapBlank_q;

  assign nibbleSel = 4'(snapNum_d >> {idx_d, 2'b00});
  assign dpSel     = 1'(snapDp_d >> idx_d);
  assign blankSel  = 1'(snapBlank_d >> idx_d);

  seg_decode u_decode (
    .nibble_i (nibbleSel),
    .seg_o    (segPat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      snapNum_q   <= '0;
      snapDp_q    <= '0;
      snapBlank_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snapNum_q   <= snapNum_d;
      snapDp_q    <= snapDp_d;
      snapBlank_q <= snapBlank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (tick) begin
      state_d = SCAN;
      idx_d   = frameTick ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    selEn_d = selEn_q;
    y_d     = y_q;
    dp_d    = dp_q;
    fs_d    = 1'b0;
    if (tick) begin
      fs_d = frameTick;
      if (blankSel) begin
        selEn_d = EN_ALL;
        y_d     = SEG_OFF;
        dp_d    = 1'b1;
      end else begin
        selEn_d = ~(DIGITS'(1) << idx_d);
        y_d     = segPat;
        dp_d    = ~dpSel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selEn_q <= EN_ALL;
      y_q     <= SEG_OFF;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      selEn_q <= selEn_d;
      y_q     <= y_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign y           = y_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

`ifdef SEG_DIM_EN
  localparam int PH = DIV / 8;
  localparam int PW = (PH > 1) ? $clog2(PH) : 1;
  localparam logic [PW-1:0] PH_MAX = PW'(PH - 1);

  logic [PW-1:0]     phCnt_q, phCnt_d;
  logic [2:0]        phase_q, phase_d;
  logic [2:0]        bright_q, brightEff;
  logic [DIGITS-1:0] en_q, en_d;

  // Each slot restarts at phase 0 and steps through 8 phases of DIV/8 cycles.
  always_comb begin
    phCnt_d = phCnt_q + 1'b1;
    phase_d = phase_q;
    if (tick) begin
      phCnt_d = '0;
      phase_d = '0;
    end else if (phCnt_q == PH_MAX) begin
      phCnt_d = '0;
      phase_d = phase_q + 1'b1;
    end
  end

  assign brightEff = tick ? bright : bright_q;
  assign en_d      = (phase_d <= brightEff) ? selEn_d : EN_ALL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phCnt_q  <= '0;
      phase_q  <= '0;
      bright_q <= '0;
      en_q     <= EN_ALL;
    end else begin
      phCnt_q  <= phCnt_d;
      phase_q  <= phase_d;
      bright_q <= brightEff;
      en_q     <= en_d;
    end
  end

  assign en = en_q;
`else
  assign en = selEn_q;
`endif

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with DIGITS=4, DIV=8.
// Builds with or without SEG_DIM_EN; the brightness section runs only when it is defined.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] num;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
`ifdef SEG_DIM_EN
  logic [2:0]  bright;
`endif
  logic [6:0]  y;
  logic        dp;
  logic [3:0]  en;
  logic        frame_start;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: edges since reset release and the frame snapshot.
  int          t;
  bit          modelOn;
  logic [15:0] snapNum;
  logic [3:0]  snapDp;
  logic [3:0]  snapBlank;
  logic [6:0]  expY;
  logic        expDp;
  logic [3:0]  expEn;
  logic        expFs;
  logic [6:0]  segRef [16];

  typedef struct {
    logic [15:0]     num;
    logic [3:0]      dpIn;
    logic [3:0]      blank;
    logic [3:0][6:0] expY;
    logic [3:0][3:0] expEn;
    logic [3:0]      expDp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num         (num),
    .dp_in       (dp_in),
    .blank       (blank),
`ifdef SEG_DIM_EN
    .bright      (bright),
`endif
    .y           (y),
    .dp          (dp),
    .en          (en),
    .frame_start (frame_start)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    t         = 0;
    snapNum   = '0;
    snapDp    = '0;
    snapBlank = '0;
    expY      = 7'h7F;
    expDp     = 1'b1;
    expEn     = 4'hF;
    expFs     = 1'b0;
  endtask

  // Slot boundaries fall every DIV edges after release; the first one selects digit 0.
  task automatic modelEdge();
    int slot;
    int digit;
    t++;
    expFs = 1'b0;
    if (t >= DIV && (t % DIV) == 0) begin
      slot  = t / DIV - 1;
      digit = slot % DIGITS;
      if (digit == 0) begin
        snapNum   = num;
        snapDp    = dp_in;
        snapBlank = blank;
        expFs     = 1'b1;
      end
      if (snapBlank[digit]) begin
        expEn = 4'hF;
        expY  = 7'h7F;
        expDp = 1'b1;
      end else begin
        expEn = ~(4'b0001 << digit);
        expY  = segRef[snapNum[4*digit +: 4]];
        expDp = ~snapDp[digit];
      end
    end
  endtask

  task automatic checkOutput();
    if (modelOn) begin
      checkVal("modelEn", en, expEn);
      checkVal("modelY", y, expY);
      checkVal("modelDp", dp, expDp);
      checkVal("modelFrameStart", frame_start, expFs);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (rst_n && modelOn) modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) stepClock();
  endtask

  task automatic applyStimulus(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b);
    num   = n;
    dp_in = d;
    blank = b;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("rstEn", en, 4'hF);
    checkVal("rstY", y, 7'h7F);
    checkVal("rstDp", dp, 1'b1);
    checkVal("rstFrameStart", frame_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitFrame();
    for (int i = 0; i < 4 * DIV + 2; i++) begin
      stepClock();
      if (frame_start === 1'b1) break;
    end
    checkVal("frameWait", frame_start, 1'b1);
  endtask

  initial begin
    logic [6:0] tearY [4];
    logic [3:0] relSeq [4];
    int n;
    int low;

    segRef = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {7'h4F, 7'h12, 7'h06, 7'h4C},
                {4'h7, 4'hB, 4'hD, 4'hE}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0001, 4'b0100, {7'h08, 7'h7F, 7'h31, 7'h42},
                {4'h7, 4'hF, 4'hD, 4'hE}, 4'b1110};
    vecs[2] = '{16'h89EF, 4'b1010, 4'b0000, {7'h00, 7'h04, 7'h30, 7'h38},
                {4'h7, 4'hB, 4'hD, 4'hE}, 4'b0101};
    vecs[3] = '{16'h5670, 4'b1111, 4'b1001, {7'h7F, 7'h20, 7'h0F, 7'h7F},
                {4'hF, 4'hB, 4'hD, 4'hF}, 4'b1001};
    tearY  = '{7'h42, 7'h31, 7'h60, 7'h08};
    relSeq = '{4'hD, 4'hB, 4'h7, 4'hE};

    modelOn = 1'b1;
    rst_n   = 1'b0;
    applyStimulus(16'h0000, 4'h0, 4'h0);
`ifdef SEG_DIM_EN
    bright = 3'd7;
`endif
    modelReset();

    @(posedge clk);
    #1;
    checkVal("initEn", en, 4'hF);
    checkVal("initY", y, 7'h7F);
    checkVal("initDp", dp, 1'b1);
    checkVal("initFrameStart", frame_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one full frame per record, checked slot by slot against constants.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].num, vecs[i].dpIn, vecs[i].blank);
      waitFrame();
      for (int d = 0; d < DIGITS; d++) begin
        checkVal($sformatf("vec%0d_y%0d", i, d), y, vecs[i].expY[d]);
        checkVal($sformatf("vec%0d_en%0d", i, d), en, vecs[i].expEn[d]);
        checkVal($sformatf("vec%0d_dp%0d", i, d), dp, vecs[i].expDp[d]);
        if (d < DIGITS - 1) stepN(DIV);
      end
    end

    // Input change while digit 2 is shown must not tear the current frame.
    applyStimulus(16'h1234, 4'h0, 4'h0);
    waitFrame();
    stepN(2 * DIV + 2);
    applyStimulus(16'hABCD, 4'h0, 4'h0);
    checkVal("tearDigit2", y, 7'h12);
    stepN(DIV - 2);
    checkVal("tearDigit3", y, 7'h4F);
    for (int d = 0; d < DIGITS; d++) begin
      stepN(DIV);
      checkVal($sformatf("tearNext%0d", d), y, tearY[d]);
    end

    // After release, digit 0 appears exactly DIV edges later, then one slot per DIV.
    applyStimulus(16'h1234, 4'h0, 4'h0);
    doReset();
    for (int i = 1; i < DIV; i++) begin
      stepClock();
      checkVal("relIdle", en, 4'hF);
    end
    stepClock();
    checkVal("relFirstEn", en, 4'hE);
    checkVal("relFirstFs", frame_start, 1'b1);
    for (int d = 0; d < 4; d++) begin
      stepN(DIV);
      checkVal($sformatf("relSeq%0d", d), en, relSeq[d]);
    end

    // Reset pulsed mid-slot during digit 2.
    waitFrame();
    stepN(2 * DIV + 3);
    doReset();
    n = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      stepClock();
      n++;
      if (en !== 4'hF) break;
    end
    checkVal("midResetDelay", n, DIV);
    checkVal("midResetEn", en, 4'hE);

    // Randomised inputs and occasional resets against the reference model.
    for (int c = 0; c < 900; c++) begin
      stepClock();
      if ($urandom_range(0, 3) == 0)
        applyStimulus(16'($urandom), 4'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      if ($urandom_range(0, 199) == 0) doReset();
    end

`ifdef SEG_DIM_EN
    // Brightness: count enabled cycles within a digit-0 slot.
    modelOn = 1'b0;
    applyStimulus(16'h1234, 4'h0, 4'h0);
    bright = 3'd1;
    waitFrame();
    low = 0;
    for (int i = 0; i < DIV; i++) begin
      if (en !== 4'hF) low++;
      if (i < 2) checkVal($sformatf("dim1Phase%0d", i), en, 4'hE);
      @(posedge clk);
      #1;
    end
    checkVal("dim1LowCycles", low, 2);
    bright = 3'd7;
    stepN(DIV);
    low = 0;
    for (int i = 0; i < DIV; i++) begin
      if (en !== 4'hF) low++;
      @(posedge clk);
      #1;
    end
    checkVal("dim7LowCycles", low, DIV);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
